// File: rtl/nv_nvdla_cmac_reg_pingpong.sv
// CMAC register front end: local STATUS/POINTER decode, ping-pong routing to D0/D1, op_en and consumer tracking.
// Optional write lock on busy groups: define NVDLA_CMAC_PINGPONG_WR_LOCK_EN.
module nv_nvdla_cmac_reg_pingpong #(
  parameter logic [11:0] DUAL_BASE = 12'h008,
  parameter logic [11:0] OP_EN_OFS = 12'h008
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic [11:0] reg_offset,
  input  logic [31:0] reg_wr_data,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  output logic [31:0] reg_rd_data,
  output logic        reg_rd_vld,
  output logic [11:0] d0_reg_offset,
  output logic [11:0] d1_reg_offset,
  output logic [31:0] d0_reg_wr_data,
  output logic [31:0] d1_reg_wr_data,
  output logic        d0_reg_wr_en,
  output logic        d1_reg_wr_en,
  input  logic [31:0] d0_reg_rd_data,
  input  logic [31:0] d1_reg_rd_data,
  input  logic        d0_op_en_trigger,
  input  logic        d1_op_en_trigger,
  output logic        d0_op_en,
  output logic        d1_op_en,
  input  logic        d0_conv_mode,
  input  logic        d1_conv_mode,
  input  logic [1:0]  d0_proc_precision,
  input  logic [1:0]  d1_proc_precision,
  input  logic        dp2reg_done,
  output logic        reg2dp_op_en,
  output logic        reg2dp_conv_mode,
  output logic [1:0]  reg2dp_proc_precision,
  output logic [1:0]  done_intr
);

  logic        producer_q, producer_d;
  logic        consumer_q, consumer_d;
  logic [1:0]  op_en_q, op_en_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_vld_q;
  logic [1:0]  done_intr_q, done_intr_d;

  logic        is_dual, sel_status, sel_pointer;
  logic        wr_block, dual_wr, done_fire, wr_err;
  logic [1:0]  trig;
  logic [1:0]  grp_status [2];
  logic [31:0] status_word, pointer_word, dual_rd;

  assign is_dual     = (reg_offset >= DUAL_BASE);
  assign sel_status  = (reg_offset == 12'h000);
  assign sel_pointer = (reg_offset == 12'h004);

`ifdef NVDLA_CMAC_PINGPONG_WR_LOCK_EN
  logic wr_err_q, wr_err_d;

  // A group that is armed or running must not have its configuration disturbed.
  assign wr_block = is_dual & op_en_q[producer_q];
  assign wr_err   = wr_err_q;

  always_comb begin
    wr_err_d = wr_err_q;
    if (reg_wr_en && sel_status && reg_wr_data[31]) wr_err_d = 1'b0;
    if (reg_wr_en && wr_block)                      wr_err_d = 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) wr_err_q <= 1'b0;
    else                wr_err_q <= wr_err_d;
  end
`else
  assign wr_block = 1'b0;
  assign wr_err   = 1'b0;
`endif

  assign dual_wr        = reg_wr_en & is_dual & ~wr_block;
  assign d0_reg_wr_en   = dual_wr & ~producer_q;
  assign d1_reg_wr_en   = dual_wr &  producer_q;
  assign d0_reg_offset  = reg_offset;
  assign d1_reg_offset  = reg_offset;
  assign d0_reg_wr_data = reg_wr_data;
  assign d1_reg_wr_data = reg_wr_data;

  // A trigger is only honoured while the bus is actually addressing OP_ENABLE.
  assign trig[0] = d0_op_en_trigger & (reg_offset == OP_EN_OFS);
  assign trig[1] = d1_op_en_trigger & (reg_offset == OP_EN_OFS);

  assign d0_op_en              = op_en_q[0];
  assign d1_op_en              = op_en_q[1];
  assign reg2dp_op_en          = op_en_q[consumer_q];
  assign reg2dp_conv_mode      = consumer_q ? d1_conv_mode : d0_conv_mode;
  assign reg2dp_proc_precision = consumer_q ? d1_proc_precision : d0_proc_precision;
  assign done_fire             = dp2reg_done & reg2dp_op_en;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_status
      assign grp_status[gi] = !op_en_q[gi]                 ? 2'd0 :
                              (consumer_q == 1'(gi))       ? 2'd1 : 2'd2;
    end
  endgenerate

  assign status_word  = {wr_err, 13'd0, grp_status[1], 14'd0, grp_status[0]};
  assign pointer_word = {15'd0, consumer_q, 15'd0, producer_q};
  assign dual_rd      = producer_q ? d1_reg_rd_data : d0_reg_rd_data;

  always_comb begin
    rd_data_d = 32'd0;
    if (is_dual)          rd_data_d = dual_rd;
    else if (sel_status)  rd_data_d = status_word;
    else if (sel_pointer) rd_data_d = pointer_word;
  end

  // Trigger is applied after the done clear so a same-cycle re-arm survives.
  always_comb begin
    op_en_d     = op_en_q;
    done_intr_d = 2'b00;
    consumer_d  = consumer_q ^ done_fire;
    producer_d  = (reg_wr_en && sel_pointer) ? reg_wr_data[0] : producer_q;
    if (done_fire) begin
      op_en_d[consumer_q]     = 1'b0;
      done_intr_d[consumer_q] = 1'b1;
    end
    if (trig[0]) op_en_d[0] = reg_wr_data[0];
    if (trig[1]) op_en_d[1] = reg_wr_data[0];
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      producer_q  <= 1'b0;
      consumer_q  <= 1'b0;
      op_en_q     <= 2'b00;
      rd_data_q   <= 32'd0;
      rd_vld_q    <= 1'b0;
      done_intr_q <= 2'b00;
    end else begin
      producer_q  <= producer_d;
      consumer_q  <= consumer_d;
      op_en_q     <= op_en_d;
      rd_vld_q    <= reg_rd_en;
      done_intr_q <= done_intr_d;
      if (reg_rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign reg_rd_data = rd_data_q;
  assign reg_rd_vld  = rd_vld_q;
  assign done_intr   = done_intr_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_reg_pingpong.sv
// Directed bench for nv_nvdla_cmac_reg_pingpong; read results go through a scoreboard queue.
// Group D0/D1 register files are stubbed; lock checks run when NVDLA_CMAC_PINGPONG_WR_LOCK_EN is defined.
module tb_nv_nvdla_cmac_reg_pingpong;

`ifdef NVDLA_CMAC_PINGPONG_WR_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en, reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_vld;
  logic [11:0] d0_reg_offset, d1_reg_offset;
  logic [31:0] d0_reg_wr_data, d1_reg_wr_data;
  logic        d0_reg_wr_en, d1_reg_wr_en;
  logic [31:0] d0_reg_rd_data, d1_reg_rd_data;
  logic        d0_op_en_trigger, d1_op_en_trigger;
  logic        d0_op_en, d1_op_en;
  logic        dp2reg_done;
  logic        reg2dp_op_en, reg2dp_conv_mode;
  logic [1:0]  reg2dp_proc_precision;
  logic [1:0]  done_intr;

  always #5 clk = ~clk;

  nv_nvdla_cmac_reg_pingpong dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(srst),
    .reg_offset(reg_offset), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_vld(reg_rd_vld),
    .d0_reg_offset(d0_reg_offset), .d1_reg_offset(d1_reg_offset),
    .d0_reg_wr_data(d0_reg_wr_data), .d1_reg_wr_data(d1_reg_wr_data),
    .d0_reg_wr_en(d0_reg_wr_en), .d1_reg_wr_en(d1_reg_wr_en),
    .d0_reg_rd_data(d0_reg_rd_data), .d1_reg_rd_data(d1_reg_rd_data),
    .d0_op_en_trigger(d0_op_en_trigger), .d1_op_en_trigger(d1_op_en_trigger),
    .d0_op_en(d0_op_en), .d1_op_en(d1_op_en),
    .d0_conv_mode(1'b0), .d1_conv_mode(1'b1),
    .d0_proc_precision(2'b01), .d1_proc_precision(2'b10),
    .dp2reg_done(dp2reg_done),
    .reg2dp_op_en(reg2dp_op_en), .reg2dp_conv_mode(reg2dp_conv_mode),
    .reg2dp_proc_precision(reg2dp_proc_precision),
    .done_intr(done_intr)
  );

  // Group stubs: OP_ENABLE at 0x008 reads back op_en, 0x00C returns a group tag.
  function automatic logic [31:0] grp_rd(input logic n, input logic [11:0] ofs, input logic en);
    case (ofs)
      12'h008: return {31'd0, en};
      12'h00C: return 32'hA000_0000 | 32'(n);
      default: return 32'd0;
    endcase
  endfunction

  assign d0_reg_rd_data   = grp_rd(1'b0, d0_reg_offset, d0_op_en);
  assign d1_reg_rd_data   = grp_rd(1'b1, d1_reg_offset, d1_op_en);
  assign d0_op_en_trigger = d0_reg_wr_en && (d0_reg_offset == 12'h008);
  assign d1_op_en_trigger = d1_reg_wr_en && (d1_reg_offset == 12'h008);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    string       tag;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each read must return exactly one cycle after its request.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
      rd_exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_vld"}, 32'(reg_rd_vld), 32'd1);
      chk(e.tag, reg_rd_data, e.data);
      $display("read  %-12s ofs-data=0x%08h expected=0x%08h", e.tag, reg_rd_data, e.data);
    end else if (reg_rd_vld) begin
      chk("spurious_vld", 32'(reg_rd_vld), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] ofs, input logic [31:0] exp, input string tag);
    reg_offset = ofs;
    reg_rd_en  = 1'b1;
    sb.push_back('{cyc, exp, tag});
    tick();
    reg_rd_en  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] ofs, input logic [31:0] data);
    reg_offset  = ofs;
    reg_wr_data = data;
    reg_wr_en   = 1'b1;
    tick();
    reg_wr_en   = 1'b0;
    $display("write ofs=0x%03h data=0x%08h", ofs, data);
  endtask

  task automatic pulse_done();
    dp2reg_done = 1'b1;
    tick();
    dp2reg_done = 1'b0;
  endtask

  initial begin
    srst = 1'b1; reg_offset = '0; reg_wr_data = '0;
    reg_wr_en = 1'b0; reg_rd_en = 1'b0; dp2reg_done = 1'b0;
    repeat (3) tick();
    chk("rst_rd_vld", 32'(reg_rd_vld), 32'd0);
    chk("rst_rd_data", reg_rd_data, 32'd0);
    chk("rst_intr", 32'(done_intr), 32'd0);
    chk("rst_op_en", 32'({d1_op_en, d0_op_en, reg2dp_op_en}), 32'd0);
    chk("rst_prec", 32'(reg2dp_proc_precision), 32'd1);
    srst = 1'b0;
    tick();

    rd(12'h004, 32'h0000_0000, "ptr_rst");
    rd(12'h000, 32'h0000_0000, "stat_rst");

    // Arm group 0 through the producer.
    reg_offset = 12'h008; reg_wr_data = 32'd1; reg_wr_en = 1'b1;
    #1;
    chk("d_wr_en_p0", 32'({d1_reg_wr_en, d0_reg_wr_en}), 32'b01);
    chk("bcast_data", d1_reg_wr_data, 32'd1);
    tick();
    reg_wr_en = 1'b0;
    chk("op_en0", 32'(d0_op_en), 32'd1);
    chk("dp_op_en", 32'(reg2dp_op_en), 32'd1);
    rd(12'h000, 32'h0000_0001, "stat_run0");

    wr(12'h004, 32'd1);
    reg_offset = 12'h008; reg_wr_data = 32'd1; reg_wr_en = 1'b1;
    #1;
    chk("d_wr_en_p1", 32'({d1_reg_wr_en, d0_reg_wr_en}), 32'b10);
    tick();
    reg_wr_en = 1'b0;
    rd(12'h000, 32'h0002_0001, "stat_pend1");
    rd(12'h004, 32'h0000_0001, "ptr_p1");
    rd(12'h00C, 32'hA000_0001, "dual_rd_d1");

    pulse_done();
    chk("intr_g0", 32'(done_intr), 32'b01);
    chk("cons1_prec", 32'(reg2dp_proc_precision), 32'b10);
    chk("cons1_conv", 32'(reg2dp_conv_mode), 32'd1);
    chk("op_en0_clr", 32'(d0_op_en), 32'd0);
    tick();
    chk("intr_once", 32'(done_intr), 32'd0);
    rd(12'h000, 32'h0001_0000, "stat_cons1");
    rd(12'h004, 32'h0001_0001, "ptr_c1p1");

    pulse_done();
    chk("intr_g1", 32'(done_intr), 32'b10);
    chk("dp_op_en_off", 32'(reg2dp_op_en), 32'd0);
    pulse_done();
    chk("idle_done_intr", 32'(done_intr), 32'd0);
    chk("idle_done_cons", 32'(reg2dp_proc_precision), 32'b01);
    rd(12'h004, 32'h0000_0001, "ptr_c0p1");

    // Done and re-arm of the consumer group in the same cycle.
    wr(12'h004, 32'd0);
    wr(12'h008, 32'd1);
    chk("op_en0_rearm", 32'(d0_op_en), 32'd1);
`ifndef NVDLA_CMAC_PINGPONG_WR_LOCK_EN
    reg_offset = 12'h008; reg_wr_data = 32'd1; reg_wr_en = 1'b1; dp2reg_done = 1'b1;
    tick();
    reg_wr_en = 1'b0; dp2reg_done = 1'b0;
`else
    pulse_done();
`endif
    chk("same_cyc_intr", 32'(done_intr), 32'b01);
    chk("same_cyc_cons", 32'(reg2dp_proc_precision), 32'b10);
    chk("same_cyc_op_en0", 32'(d0_op_en), LOCK ? 32'd0 : 32'd1);

    // Simultaneous read and write of POINTER returns the old value.
    reg_offset = 12'h004; reg_wr_data = 32'd1; reg_wr_en = 1'b1; reg_rd_en = 1'b1;
    sb.push_back('{cyc, 32'h0001_0000, "rdwr_ptr"});
    tick();
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    rd(12'h004, 32'h0001_0001, "ptr_after");

    // Back-to-back done with both groups armed, consumer = 1.
    wr(12'h004, 32'd0);
    wr(12'h008, 32'd1);
    wr(12'h004, 32'd1);
    wr(12'h008, 32'd1);
    chk("both_armed", 32'({d1_op_en, d0_op_en}), 32'b11);
    dp2reg_done = 1'b1;
    tick();
    chk("b2b_intr1", 32'(done_intr), 32'b10);
    tick();
    dp2reg_done = 1'b0;
    chk("b2b_intr0", 32'(done_intr), 32'b01);
    chk("b2b_op_en", 32'({d1_op_en, d0_op_en}), 32'b00);
    chk("b2b_cons", 32'(reg2dp_proc_precision), 32'b10);
    tick();
    chk("b2b_quiet", 32'(done_intr), 32'd0);

    // Reserved single offsets and undecoded dual offsets.
    rd(12'h002, 32'd0, "rd_rsvd");
    rd(12'h010, 32'd0, "rd_undec");
    reg_offset = 12'h002; reg_wr_data = 32'hFFFF_FFFF; reg_wr_en = 1'b1;
    #1;
    chk("rsvd_wr_drop", 32'({d1_reg_wr_en, d0_reg_wr_en}), 32'b00);
    chk("bcast_ofs", 32'(d0_reg_offset), 32'h002);
    tick();
    reg_wr_en = 1'b0;
    rd(12'h004, 32'h0001_0001, "ptr_rsvd");

    // Reset in the middle of a layer.
    wr(12'h008, 32'd1);
    chk("mid_armed", 32'(reg2dp_op_en), 32'd1);
    srst = 1'b1; dp2reg_done = 1'b1;
    tick();
    srst = 1'b0; dp2reg_done = 1'b0;
    chk("mid_rst_intr", 32'(done_intr), 32'd0);
    chk("mid_rst_op_en", 32'({d1_op_en, d0_op_en}), 32'd0);
    tick();
    chk("mid_rst_intr2", 32'(done_intr), 32'd0);
    rd(12'h004, 32'd0, "ptr_mid_rst");
    rd(12'h000, 32'd0, "stat_mid_rst");

`ifdef NVDLA_CMAC_PINGPONG_WR_LOCK_EN
    wr(12'h008, 32'd1);
    reg_offset = 12'h00C; reg_wr_data = 32'd5; reg_wr_en = 1'b1;
    #1;
    chk("lock_wr_en", 32'({d1_reg_wr_en, d0_reg_wr_en}), 32'b00);
    tick();
    reg_wr_en = 1'b0;
    rd(12'h000, 32'h8000_0001, "stat_wr_err");
    wr(12'h000, 32'h8000_0000);
    rd(12'h000, 32'h0000_0001, "stat_err_clr");
`endif

    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
